// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and baud timing helpers.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  function automatic int unsigned bit_period(input int unsigned clk_freq, input int unsigned baud);
    return clk_freq / baud;
  endfunction

  function automatic int unsigned half_period(input int unsigned clk_freq, input int unsigned baud);
    return bit_period(clk_freq, baud) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous RX pin plus falling-edge detect.
// Everything resets to 1 (line idle) so reset release never looks like a start edge.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic sync_1;
  logic sync_2;
  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
      prev   <= 1'b1;
    end else begin
      sync_1 <= rx;
      sync_2 <= sync_1;
      prev   <= sync_2;
    end
  end

  assign rx_s = sync_2;
  assign fall = prev & ~sync_2;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling FSM with sticky ready/frame-error/overrun flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 100000000,
  parameter int unsigned BAUD_RATE = 115200
) (
  input  logic        CLK_100MHz,
  input  logic        RESET_N,
  input  logic        RX,
  input  logic        CLEAR,
  output logic        RX_BUSY,
  output logic        RX_READY,
  output logic        FRAME_ERR,
  output logic        OVERRUN,
  output logic [15:0] OUT
);

  localparam int unsigned BIT_PERIOD  = bit_period(CLK_FREQ, BAUD_RATE);
  localparam int unsigned HALF_PERIOD = half_period(CLK_FREQ, BAUD_RATE);
  localparam logic [31:0] BIT_LAST    = 32'(BIT_PERIOD - 1);
  localparam logic [31:0] HALF_LAST   = 32'(HALF_PERIOD - 1);

  logic        rx_s;
  logic        fall;

  uart_state_t state_q, state_d;
  logic [31:0] clk_cycles_q, clk_cycles_d;
  logic [3:0]  bit_index_q, bit_index_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        ready_q, ready_d;
  logic        ferr_q, ferr_d;
  logic        ovr_q, ovr_d;

  uart_rx_sync u_sync (
    .clk   (CLK_100MHz),
    .rst_n (RESET_N),
    .rx    (RX),
    .rx_s  (rx_s),
    .fall  (fall)
  );

  always_ff @(posedge CLK_100MHz or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= IDLE;
      clk_cycles_q <= '0;
      bit_index_q  <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      ready_q      <= 1'b0;
      ferr_q       <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      clk_cycles_q <= clk_cycles_d;
      bit_index_q  <= bit_index_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      ready_q      <= ready_d;
      ferr_q       <= ferr_d;
      ovr_q        <= ovr_d;
    end
  end

  // CLEAR is applied first so that a completion or framing error in the same cycle overrides it.
  always_comb begin
    state_d      = state_q;
    clk_cycles_d = clk_cycles_q;
    bit_index_d  = bit_index_q;
    shift_d      = shift_q;
    data_d       = data_q;
    ready_d      = ready_q;
    ferr_d       = ferr_q;
    ovr_d        = ovr_q;

    if (CLEAR) begin
      ready_d = 1'b0;
      ferr_d  = 1'b0;
      ovr_d   = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (fall) begin
          clk_cycles_d = '0;
          state_d      = START;
        end
      end
      START: begin
        if (clk_cycles_q == HALF_LAST) begin
          if (!rx_s) begin
            clk_cycles_d = '0;
            bit_index_d  = '0;
            state_d      = DATA;
          end else begin
            state_d = IDLE;
          end
        end else begin
          clk_cycles_d = clk_cycles_q + 32'd1;
        end
      end
      DATA: begin
        if (clk_cycles_q == BIT_LAST) begin
          clk_cycles_d                = '0;
          shift_d[bit_index_q[2:0]]   = rx_s;
          bit_index_d                 = bit_index_q + 4'd1;
          if (bit_index_q == 4'd7) state_d = STOP;
        end else begin
          clk_cycles_d = clk_cycles_q + 32'd1;
        end
      end
      STOP: begin
        if (clk_cycles_q == BIT_LAST) begin
          clk_cycles_d = '0;
          state_d      = IDLE;
          if (rx_s) begin
            data_d  = shift_q;
            ready_d = 1'b1;
            if (ready_q && !CLEAR) ovr_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          clk_cycles_d = clk_cycles_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign RX_BUSY   = (state_q != IDLE);
  assign RX_READY  = ready_q;
  assign FRAME_ERR = ferr_q;
  assign OVERRUN   = ovr_q;
  assign OUT       = {8'h00, data_q};

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx: drives 8N1 frames on RX and checks flags/OUT.
module tb_uart_rx;

  localparam int BIT = 868;

  logic        clk;
  logic        rst_n;
  logic        rx;
  logic        clear;
  logic        rx_busy;
  logic        rx_ready;
  logic        frame_err;
  logic        overrun;
  logic [15:0] out_bus;

  int compare_count  = 0;
  int mismatch_count = 0;

  uart_rx dut (
    .CLK_100MHz (clk),
    .RESET_N    (rst_n),
    .RX         (rx),
    .CLEAR      (clear),
    .RX_BUSY    (rx_busy),
    .RX_READY   (rx_ready),
    .FRAME_ERR  (frame_err),
    .OVERRUN    (overrun),
    .OUT        (out_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    compare_count++;
    if (actual !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Transmitter model: start bit, 8 data bits LSB first, then the given stop level.
  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit, input int period);
    rx = 1'b0;
    repeat (period) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      repeat (period) @(negedge clk);
    end
    rx = stop_bit;
    repeat (period) @(negedge clk);
  endtask

  task automatic idle(input int cycles);
    rx = 1'b1;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic pulseClear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
  endtask

  task automatic checkFlags(input string tag, input logic busy, input logic ready,
                            input logic ferr, input logic ovr, input logic [15:0] data);
    checkOutput({tag, " busy"},    {15'd0, rx_busy},   {15'd0, busy});
    checkOutput({tag, " ready"},   {15'd0, rx_ready},  {15'd0, ready});
    checkOutput({tag, " ferr"},    {15'd0, frame_err}, {15'd0, ferr});
    checkOutput({tag, " overrun"}, {15'd0, overrun},   {15'd0, ovr});
    checkOutput({tag, " out"},     out_bus,            data);
  endtask

  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    clear = 1'b0;
    repeat (5) @(negedge clk);
    checkFlags("reset", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    rst_n = 1'b1;
    idle(20);

    // Valid byte with a good stop bit
    applyStimulus(8'hA5, 1'b1, BIT);
    checkFlags("t1 A5", 1'b0, 1'b1, 1'b0, 1'b0, 16'h00A5);
    idle(50);
    pulseClear();
    checkFlags("t1 clear", 1'b0, 1'b0, 1'b0, 1'b0, 16'h00A5);

    // Two bytes without acknowledge produce an overrun; newest byte wins
    applyStimulus(8'h3C, 1'b1, BIT);
    idle(50);
    checkFlags("t2 3C", 1'b0, 1'b1, 1'b0, 1'b0, 16'h003C);
    applyStimulus(8'hC3, 1'b1, BIT);
    idle(50);
    checkFlags("t2 C3", 1'b0, 1'b1, 1'b0, 1'b1, 16'h00C3);
    pulseClear();
    checkFlags("t2 clear", 1'b0, 1'b0, 1'b0, 1'b0, 16'h00C3);

    // Stop bit held low, then the line stays low as a break
    applyStimulus(8'h55, 1'b0, BIT);
    checkFlags("t3 ferr", 1'b0, 1'b0, 1'b1, 1'b0, 16'h00C3);
    repeat (2000) @(negedge clk);
    checkFlags("t3 break", 1'b0, 1'b0, 1'b1, 1'b0, 16'h00C3);
    idle(50);
    pulseClear();
    checkFlags("t3 clear", 1'b0, 1'b0, 1'b0, 1'b0, 16'h00C3);

    // Short low glitch is rejected at the start-bit sample
    rx = 1'b0;
    repeat (200) @(negedge clk);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("t4 busy during glitch", {15'd0, rx_busy}, 16'h0001);
    repeat (500) @(negedge clk);
    checkFlags("t4 glitch", 1'b0, 1'b0, 1'b0, 1'b0, 16'h00C3);

    // Reset in the middle of data bit 4 aborts the frame
    fork
      applyStimulus(8'hFF, 1'b1, BIT);
      begin
        repeat (5 * BIT + 400) @(negedge clk);
        checkOutput("t5 busy before reset", {15'd0, rx_busy}, 16'h0001);
        rst_n = 1'b0;
        #1;
        checkFlags("t5 in reset", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        repeat (20) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    idle(50);
    checkFlags("t5 after frame", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    applyStimulus(8'h01, 1'b1, BIT);
    checkFlags("t5 01", 1'b0, 1'b1, 1'b0, 1'b0, 16'h0001);
    idle(50);
    pulseClear();

    // Baud tolerance: +2% and -2% line rates
    applyStimulus(8'h0F, 1'b1, 851);
    idle(50);
    checkFlags("t6 fast", 1'b0, 1'b1, 1'b0, 1'b0, 16'h000F);
    pulseClear();
    applyStimulus(8'h0F, 1'b1, 885);
    idle(50);
    checkFlags("t6 slow", 1'b0, 1'b1, 1'b0, 1'b0, 16'h000F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
